// File: rtl/led_status_arbiter.sv
// Front-panel LED arbiter: bounce pattern, per-port status or software
// override, chosen every cycle and driven from registers.
module led_status_arbiter #(
    parameter int NLEDS        = 8,
    parameter int STRETCH_BITS = 22,
    parameter int IDLE_BITS    = 27,
    parameter int OVR_BITS     = 28,
    parameter int BLINK_BITS   = 23
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NLEDS-1:0] i_bounce,
    input  logic [NLEDS-1:0] i_link,
    input  logic [NLEDS-1:0] i_activity,
    input  logic             i_ovr_stb,
    input  logic [NLEDS-1:0] i_ovr_leds,
    input  logic             i_ovr_release,
    output logic [NLEDS-1:0] o_leds,
    output logic [1:0]       o_mode
);

    typedef enum logic [1:0] {
        ST_BOUNCE   = 2'd0,
        ST_STATUS   = 2'd1,
        ST_OVERRIDE = 2'd2
    } state_t;

    localparam logic [STRETCH_BITS-1:0] STRETCH_ONE = 1;
    localparam logic [IDLE_BITS-1:0]    IDLE_ONE    = 1;
    localparam logic [OVR_BITS-1:0]     OVR_ONE     = 1;
    localparam logic [BLINK_BITS-1:0]   BLINK_ONE   = 1;

    state_t state;
    state_t state_next;

    logic [STRETCH_BITS-1:0] stretch [NLEDS];
    logic [NLEDS-1:0]        stretch_busy;
    logic [IDLE_BITS-1:0]    idle_cnt;
    logic [OVR_BITS-1:0]     ovr_cnt;
    logic [NLEDS-1:0]        ovr_latch;
    logic [NLEDS-1:0]        ovr_value;
    logic [BLINK_BITS-1:0]   blink_cnt;
    logic [NLEDS-1:0]        led_next;

    logic blink_phase;
    logic any_event;
    logic idle_expired;
    logic ovr_expired;

    assign blink_phase  = blink_cnt[BLINK_BITS-1];
    assign any_event    = (|i_link) | (|i_activity);
    assign idle_expired = (idle_cnt == '0);
    assign ovr_expired  = (ovr_cnt == '0);
    assign ovr_value    = i_ovr_stb ? i_ovr_leds : ovr_latch;

    // Flag every port whose activity stretch is still running.
    always_comb begin
        stretch_busy = '0;
        for (int k = 0; k < NLEDS; k++) begin
            stretch_busy[k] = (stretch[k] != '0);
        end
    end

    // Per-port activity stretch: a pulse reloads, then count down to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NLEDS; k++) begin
                stretch[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NLEDS; k++) begin
                if (i_activity[k]) begin
                    stretch[k] <= '1;
                end else if (stretch_busy[k]) begin
                    stretch[k] <= stretch[k] - STRETCH_ONE;
                end
            end
        end
    end

    // Idle timer: held full while anything is alive, else drains to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idle_cnt <= '0;
        end else if (any_event || (|stretch_busy)) begin
            idle_cnt <= '1;
        end else if (!idle_expired) begin
            idle_cnt <= idle_cnt - IDLE_ONE;
        end
    end

    // Override latch and timeout; the timer only drains while overriding.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ovr_latch <= '0;
            ovr_cnt   <= '0;
        end else if (i_ovr_stb) begin
            ovr_latch <= i_ovr_leds;
            ovr_cnt   <= '1;
        end else if ((state == ST_OVERRIDE) && !ovr_expired) begin
            ovr_cnt <= ovr_cnt - OVR_ONE;
        end
    end

    // Free-running blink counter; its MSB is the blink phase.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_ONE;
        end
    end

    // Next state and the LED pattern that belongs to it.
    always_comb begin
        state_next = state;
        led_next   = '0;
        if (i_ovr_stb) begin
            state_next = ST_OVERRIDE;
        end else begin
            unique case (state)
                ST_BOUNCE: begin
                    if (any_event) begin
                        state_next = ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (idle_expired) begin
                        state_next = ST_BOUNCE;
                    end
                end
                ST_OVERRIDE: begin
                    if (i_ovr_release || ovr_expired) begin
                        state_next = ST_STATUS;
                    end
                end
                default: begin
                    state_next = ST_BOUNCE;
                end
            endcase
        end
        unique case (state_next)
            ST_STATUS: begin
                for (int k = 0; k < NLEDS; k++) begin
                    if (stretch_busy[k] || i_activity[k]) begin
                        led_next[k] = blink_phase;
                    end else begin
                        led_next[k] = i_link[k];
                    end
                end
            end
            ST_OVERRIDE: begin
                led_next = ovr_value;
            end
            default: begin
                led_next = i_bounce;
            end
        endcase
    end

    // State and LED drive move on the same edge so they always agree.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= ST_BOUNCE;
            o_leds <= '0;
        end else begin
            state  <= state_next;
            o_leds <= led_next;
        end
    end

    assign o_mode = state;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Self-checking bench for led_status_arbiter with small counters,
// directed scenarios followed by randomized traffic against a model.
module tb_led_status_arbiter;

    localparam int NL      = 4;
    localparam int STR_MAX = 15;
    localparam int IDL_MAX = 31;
    localparam int OVR_MAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [NL-1:0] bounce;
    logic [NL-1:0] link;
    logic [NL-1:0] act;
    logic          stb;
    logic [NL-1:0] ovr_leds;
    logic          rel;
    logic [NL-1:0] leds;
    logic [1:0]    mode;

    always #5 clk = ~clk;

    led_status_arbiter #(
        .NLEDS       (NL),
        .STRETCH_BITS(4),
        .IDLE_BITS   (5),
        .OVR_BITS    (4),
        .BLINK_BITS  (2)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_bounce     (bounce),
        .i_link       (link),
        .i_activity   (act),
        .i_ovr_stb    (stb),
        .i_ovr_leds   (ovr_leds),
        .i_ovr_release(rel),
        .o_leds       (leds),
        .o_mode       (mode)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain integers counting down per the rules.
    int          m_mode  = 0;
    logic [NL-1:0] m_leds = '0;
    int          m_str[NL];
    int          m_idle  = 0;
    int          m_ovr   = 0;
    logic [NL-1:0] m_latch = '0;
    int          m_cycle = 0;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step();
        int nm;
        logic [NL-1:0] nl;
        bit ph;
        bit anyev;
        bit anystr;
        if (rst) begin
            m_mode  = 0;
            m_leds  = '0;
            for (int k = 0; k < NL; k++) m_str[k] = 0;
            m_idle  = 0;
            m_ovr   = 0;
            m_latch = '0;
            m_cycle = 0;
            return;
        end
        ph     = (m_cycle % 4) >= 2;
        anyev  = (link != 0) || (act != 0);
        anystr = 0;
        for (int k = 0; k < NL; k++) if (m_str[k] > 0) anystr = 1;
        if (stb) nm = 2;
        else if (m_mode == 2 && (rel || m_ovr == 0)) nm = 1;
        else if (m_mode == 0 && anyev) nm = 1;
        else if (m_mode == 1 && m_idle == 0) nm = 0;
        else nm = m_mode;
        nl = '0;
        if (nm == 0) nl = bounce;
        else if (nm == 1) begin
            for (int k = 0; k < NL; k++)
                nl[k] = (m_str[k] > 0 || act[k]) ? ph : link[k];
        end else nl = stb ? ovr_leds : m_latch;
        for (int k = 0; k < NL; k++) begin
            if (act[k]) m_str[k] = STR_MAX;
            else if (m_str[k] > 0) m_str[k] = m_str[k] - 1;
        end
        if (anyev || anystr) m_idle = IDL_MAX;
        else if (m_idle > 0) m_idle = m_idle - 1;
        if (stb) m_ovr = OVR_MAX;
        else if (m_mode == 2 && m_ovr > 0) m_ovr = m_ovr - 1;
        if (stb) m_latch = ovr_leds;
        m_cycle = m_cycle + 1;
        m_mode  = nm;
        m_leds  = nl;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, "_mode"}, 8'(mode), 8'(m_mode));
        check({tag, "_leds"}, 8'(leds), 8'(m_leds));
    endtask

    int n;

    initial begin
        for (int k = 0; k < NL; k++) m_str[k] = 0;
        rst      = 1'b1;
        bounce   = '0;
        link     = '0;
        act      = '0;
        stb      = 1'b0;
        ovr_leds = '0;
        rel      = 1'b0;
        tick("rst");
        tick("rst");

        // Reset holds LEDs dark, then bounce passes through a cycle late.
        bounce = 4'b0010;
        tick("rst_hold");
        check("rst_hold_leds", 8'(leds), 8'h00);
        rst = 1'b0;
        tick("bounce");
        check("bounce_mode", 8'(mode), 8'd0);
        check("bounce_leds", 8'(leds), 8'h02);

        // Link enters STATUS; dropping it returns to BOUNCE 32 cycles on.
        link = 4'b0100;
        tick("link");
        check("link_mode", 8'(mode), 8'd1);
        check("link_leds", 8'(leds), 8'h04);
        repeat (4) tick("link_hold");
        link = '0;
        n = 0;
        do begin
            tick("idle");
            n++;
        end while (mode !== 2'd0 && n < 60);
        check("idle_return", 8'(n), 8'd32);

        // Activity stretch on LED0 while link 1 keeps STATUS.
        link = 4'b0010;
        repeat (3) tick("st_enter");
        act = 4'b0001;
        tick("act_pulse");
        act = '0;
        repeat (15) tick("stretch");
        tick("stretch_end");
        check("stretch_end_led0", 8'(leds[0]), 8'd0);

        // Override shows the latched value and times out after 16 cycles.
        link     = '0;
        ovr_leds = 4'b1010;
        stb      = 1'b1;
        tick("ovr");
        stb      = 1'b0;
        ovr_leds = '0;
        check("ovr_mode", 8'(mode), 8'd2);
        check("ovr_leds", 8'(leds), 8'h0A);
        n = 0;
        do begin
            tick("ovr_wait");
            n++;
        end while (mode !== 2'd1 && n < 40);
        check("ovr_timeout", 8'(n), 8'd16);

        // Strobe beats a simultaneous release.
        stb      = 1'b1;
        rel      = 1'b1;
        ovr_leds = 4'b0001;
        tick("stb_rel");
        stb = 1'b0;
        rel = 1'b0;
        check("stb_rel_mode", 8'(mode), 8'd2);
        check("stb_rel_leds", 8'(leds), 8'h01);
        tick("ovr_keep");
        check("ovr_keep_mode", 8'(mode), 8'd2);
        rel = 1'b1;
        tick("release");
        rel = 1'b0;
        check("release_mode", 8'(mode), 8'd1);

        // Reset mid-override with a stretch running clears everything.
        act = 4'b0100;
        tick("pre_act");
        act      = '0;
        ovr_leds = 4'b0110;
        stb      = 1'b1;
        tick("pre_ovr");
        stb = 1'b0;
        tick("in_ovr");
        rst = 1'b1;
        tick("mid_rst");
        check("mid_rst_mode", 8'(mode), 8'd0);
        check("mid_rst_leds", 8'(leds), 8'h00);
        rst = 1'b0;
        tick("post_rst");
        check("post_rst_mode", 8'(mode), 8'd0);
        act = 4'b1000;
        tick("post_act");
        act = '0;
        check("post_act_mode", 8'(mode), 8'd1);

        // Randomized bursts separated by quiet spells long enough to idle.
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 50; i++) begin
                bounce   = 4'($urandom);
                if ($urandom_range(0, 7) == 0) link = 4'($urandom);
                act      = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
                stb      = ($urandom_range(0, 24) == 0);
                ovr_leds = 4'($urandom);
                rel      = ($urandom_range(0, 14) == 0);
                rst      = ($urandom_range(0, 99) == 0);
                tick("rand");
            end
            link = '0;
            act  = '0;
            stb  = 1'b0;
            rel  = 1'b0;
            rst  = 1'b0;
            for (int i = 0; i < 70; i++) begin
                bounce = 4'($urandom);
                tick("quiet");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
